// File: rtl/controlador_de_interrupcoes_pkg.sv
// Shared types and constants for the interrupt/preemption controller.
// Pending-vector bit positions and the priority helper live here so the top stays readable.
package controlador_de_interrupcoes_pkg;

    typedef enum logic [1:0] {
        KERNEL = 2'd0,
        USER   = 2'd1,
        IRQ    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        INT_NONE    = 2'd0,
        INT_QUANTUM = 2'd1,
        INT_IO      = 2'd2,
        INT_DISK    = 2'd3
    } cause_t;

    localparam int unsigned DEFAULT_QUANTUM = 1000;

    localparam int unsigned P_TIMER = 0;
    localparam int unsigned P_IO    = 1;
    localparam int unsigned P_DISK  = 2;

    function automatic cause_t prio_cause(input logic [2:0] pend);
        cause_t c;
        c = INT_NONE;
        if (pend[P_DISK]) begin
            c = INT_DISK;
        end else if (pend[P_IO]) begin
            c = INT_IO;
        end else if (pend[P_TIMER]) begin
            c = INT_QUANTUM;
        end
        return c;
    endfunction

    function automatic logic [2:0] cause_mask(input cause_t c);
        logic [2:0] m;
        m = 3'b000;
        case (c)
            INT_DISK:    m[P_DISK]  = 1'b1;
            INT_IO:      m[P_IO]    = 1'b1;
            INT_QUANTUM: m[P_TIMER] = 1'b1;
            default:     m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/controlador_de_interrupcoes_contador_quantum.sv
// Loadable quantum down-counter: pauses when not running, holds at zero, and pulses
// o_expire on the 1 -> 0 step.
module controlador_de_interrupcoes_contador_quantum #(
    parameter int unsigned QW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [QW-1:0] i_load_val,
    input  logic          i_run,
    output logic [QW-1:0] o_count,
    output logic          o_expire
);

    logic [QW-1:0] r_count;
    logic [QW-1:0] w_count_next;

    assign o_expire = i_run && !i_load && (r_count == QW'(1));
    assign o_count  = r_count;

    always_comb begin
        w_count_next = r_count;
        if (i_load) begin
            w_count_next = i_load_val;
        end else if (i_run && (r_count != '0)) begin
            w_count_next = r_count - QW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/controlador_de_interrupcoes.sv
// Interrupt and preemption controller: quantum timer in user mode, sticky disk/input/timer
// requests, one prioritised interrupt delivered to the control unit at a time.
module controlador_de_interrupcoes #(
    parameter int unsigned QW              = 16,
    parameter int unsigned DEFAULT_QUANTUM = controlador_de_interrupcoes_pkg::DEFAULT_QUANTUM
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          userMode,
    input  logic          kernelMode,
    input  logic          stall,
    input  logic          quantum_wr,
    input  logic [QW-1:0] quantum_data,
    input  logic          io_req,
    input  logic          disk_done,
    input  logic          ack,
    output logic          irq,
    output logic [31:0]   intc,
    output logic          user_active,
    output logic [QW-1:0] quantum_left
);

    import controlador_de_interrupcoes_pkg::*;

    state_t        r_state;
    state_t        w_state_next;
    cause_t        r_cause;
    cause_t        w_cause_next;
    logic [2:0]    r_pend;
    logic [2:0]    w_pend_next;
    logic [2:0]    w_pend_set;
    logic [2:0]    w_pend_clr;
    logic          r_io_q;
    logic [QW-1:0] r_quantum;
    logic          w_load;
    logic          w_run;
    logic          w_expire;
    logic [QW-1:0] w_load_val;

    // A fresh quantum_wr in the same cycle as userMode must take effect on this entry.
    assign w_load     = (r_state == KERNEL) && userMode;
    assign w_load_val = quantum_wr ? quantum_data : r_quantum;
    assign w_run      = (r_state == USER) && !stall && !kernelMode && (r_pend == 3'b000);

    controlador_de_interrupcoes_contador_quantum #(
        .QW(QW)
    ) u_contador_quantum (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_run      (w_run),
        .o_count    (quantum_left),
        .o_expire   (w_expire)
    );

    always_comb begin
        w_pend_set         = 3'b000;
        w_pend_set[P_DISK]  = disk_done;
        w_pend_set[P_IO]    = io_req & ~r_io_q;
        w_pend_set[P_TIMER] = w_expire;
        w_pend_clr         = ((r_state == IRQ) && ack) ? cause_mask(r_cause) : 3'b000;
        // Set is applied last so a same-cycle set survives the ack clear.
        w_pend_next        = (r_pend & ~w_pend_clr) | w_pend_set;
    end

    always_comb begin
        w_state_next = r_state;
        w_cause_next = r_cause;
        case (r_state)
            KERNEL: begin
                if (userMode) begin
                    w_state_next = USER;
                end
            end
            USER: begin
                if (kernelMode) begin
                    w_state_next = KERNEL;
                end else if (r_pend != 3'b000) begin
                    w_state_next = IRQ;
                    w_cause_next = prio_cause(r_pend);
                end
            end
            IRQ: begin
                if (ack) begin
                    w_state_next = KERNEL;
                    w_cause_next = INT_NONE;
                end
            end
            default: begin
                w_state_next = KERNEL;
                w_cause_next = INT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= KERNEL;
            r_cause   <= INT_NONE;
            r_pend    <= 3'b000;
            r_io_q    <= 1'b0;
            r_quantum <= QW'(DEFAULT_QUANTUM);
        end else begin
            r_state <= w_state_next;
            r_cause <= w_cause_next;
            r_pend  <= w_pend_next;
            r_io_q  <= io_req;
            if (quantum_wr) begin
                r_quantum <= quantum_data;
            end
        end
    end

    assign irq         = (r_state == IRQ);
    assign user_active = (r_state == USER);
    assign intc        = {30'd0, r_cause};

endmodule

// File: tb/tb_controlador_de_interrupcoes.sv
// Self-checking bench: directed scenarios plus random traffic, all compared against a
// cycle-level behavioural model of the controller's rules.
module tb_controlador_de_interrupcoes;

    localparam int QW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          userMode;
    logic          kernelMode;
    logic          stall;
    logic          quantum_wr;
    logic [QW-1:0] quantum_data;
    logic          io_req;
    logic          disk_done;
    logic          ack;
    logic          irq;
    logic [31:0]   intc;
    logic          user_active;
    logic [QW-1:0] quantum_left;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 = kernel, 1 = user, 2 = delivering; m_pend indexed by cause code.
    int m_mode;
    int m_left;
    int m_quantum;
    int m_cause;
    bit m_pend [4];
    bit m_io_prev;

    controlador_de_interrupcoes #(
        .QW(QW),
        .DEFAULT_QUANTUM(1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .userMode     (userMode),
        .kernelMode   (kernelMode),
        .stall        (stall),
        .quantum_wr   (quantum_wr),
        .quantum_data (quantum_data),
        .io_req       (io_req),
        .disk_done    (disk_done),
        .ack          (ack),
        .irq          (irq),
        .intc         (intc),
        .user_active  (user_active),
        .quantum_left (quantum_left)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 50) begin
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
            end
        end
    endtask

    function automatic int top_cause();
        for (int c = 3; c >= 1; c--) begin
            if (m_pend[c]) return c;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_left    = 0;
        m_quantum = 1000;
        m_cause   = 0;
        for (int c = 0; c < 4; c++) m_pend[c] = 1'b0;
        m_io_prev = 1'b0;
    endtask

    task automatic model_step();
        int mode_n;
        int left_n;
        int cause_n;
        bit any_pend;
        bit expire;
        mode_n   = m_mode;
        left_n   = m_left;
        cause_n  = m_cause;
        any_pend = m_pend[1] | m_pend[2] | m_pend[3];
        expire   = 1'b0;
        if (m_mode == 1 && !stall && !kernelMode && !any_pend && m_left > 0) begin
            left_n = m_left - 1;
            expire = (m_left == 1);
        end
        case (m_mode)
            0: if (userMode) begin
                mode_n = 1;
                left_n = quantum_wr ? int'(quantum_data) : m_quantum;
            end
            1: if (kernelMode) begin
                mode_n = 0;
            end else if (any_pend) begin
                mode_n  = 2;
                cause_n = top_cause();
            end
            default: if (ack) begin
                mode_n        = 0;
                cause_n       = 0;
                m_pend[m_cause] = 1'b0;
            end
        endcase
        if (disk_done) m_pend[3] = 1'b1;
        if (io_req && !m_io_prev) m_pend[2] = 1'b1;
        if (expire) m_pend[1] = 1'b1;
        m_io_prev = io_req;
        if (quantum_wr) m_quantum = int'(quantum_data);
        m_mode  = mode_n;
        m_left  = left_n;
        m_cause = cause_n;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".irq"}, 32'(irq), 32'(m_mode == 2));
        check({tag, ".intc"}, intc, 32'(m_cause));
        check({tag, ".user_active"}, 32'(user_active), 32'(m_mode == 1));
        check({tag, ".quantum_left"}, 32'(quantum_left), 32'(m_left));
    endtask

    task automatic clear_inputs();
        userMode     = 1'b0;
        kernelMode   = 1'b0;
        stall        = 1'b0;
        quantum_wr   = 1'b0;
        quantum_data = '0;
        io_req       = 1'b0;
        disk_done    = 1'b0;
        ack          = 1'b0;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    // Reset is asserted between edges so its asynchronous effect is observable.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        do_reset();

        // Quantum of 5 expires and raises a quantum interrupt.
        quantum_wr = 1'b1; quantum_data = 16'd5; tick("t1_wr");
        quantum_wr = 1'b0; userMode = 1'b1;      tick("t1_enter");
        userMode = 1'b0;
        check("t1_loaded", 32'(quantum_left), 32'd5);
        for (int i = 4; i >= 0; i--) begin
            tick("t1_count");
            check("t1_left", 32'(quantum_left), 32'(i));
        end
        check("t1_no_irq_yet", 32'(irq), 32'd0);
        tick("t1_deliver");
        check("t1_irq", 32'(irq), 32'd1);
        check("t1_intc", intc, 32'd1);
        ack = 1'b1; tick("t1_ack");
        ack = 1'b0;
        check("t1_irq_clr", 32'(irq), 32'd0);
        check("t1_intc_clr", intc, 32'd0);
        check("t1_user_clr", 32'(user_active), 32'd0);

        // Disk and input together: disk first, input after re-entry.
        quantum_wr = 1'b1; quantum_data = 16'd100; userMode = 1'b1; tick("t2_enter");
        quantum_wr = 1'b0; userMode = 1'b0; tick("t2_run");
        disk_done = 1'b1; io_req = 1'b1; tick("t2_events");
        disk_done = 1'b0; tick("t2_deliver");
        check("t2_intc_disk", intc, 32'd3);
        ack = 1'b1; tick("t2_ack");
        ack = 1'b0; userMode = 1'b1; tick("t2_reenter");
        userMode = 1'b0;
        check("t2_reenter_no_irq", 32'(irq), 32'd0);
        tick("t2_deliver2");
        check("t2_intc_io", intc, 32'd2);
        ack = 1'b1; tick("t2_ack2");
        ack = 1'b0; io_req = 1'b0; tick("t2_idle");

        // Stall freezes the quantum.
        quantum_wr = 1'b1; quantum_data = 16'd10; userMode = 1'b1; tick("t3_enter");
        quantum_wr = 1'b0; userMode = 1'b0; stall = 1'b1;
        for (int i = 0; i < 20; i++) tick("t3_stall");
        check("t3_frozen", 32'(quantum_left), 32'd10);
        stall = 1'b0;
        for (int i = 0; i < 10; i++) tick("t3_run");
        check("t3_zero_no_irq", 32'(irq), 32'd0);
        tick("t3_deliver");
        check("t3_irq", 32'(irq), 32'd1);
        ack = 1'b1; tick("t3_ack");
        ack = 1'b0;

        // Input request latched while in kernel mode.
        io_req = 1'b1; tick("t4_rise");
        io_req = 1'b0;
        for (int i = 0; i < 5; i++) tick("t4_kernel");
        check("t4_kernel_no_irq", 32'(irq), 32'd0);
        userMode = 1'b1; tick("t4_enter");
        userMode = 1'b0; tick("t4_deliver");
        check("t4_intc_io", intc, 32'd2);
        ack = 1'b1; tick("t4_ack");
        ack = 1'b0;

        // Zero quantum disables the timer.
        quantum_wr = 1'b1; quantum_data = 16'd0; tick("t5_wr");
        quantum_wr = 1'b0; userMode = 1'b1; tick("t5_enter");
        userMode = 1'b0;
        for (int i = 0; i < 5000; i++) tick("t5_idle");
        check("t5_irq", 32'(irq), 32'd0);
        check("t5_left", 32'(quantum_left), 32'd0);
        kernelMode = 1'b1; tick("t5_kernel");
        kernelMode = 1'b0;
        check("t5_user_off", 32'(user_active), 32'd0);

        // Reset during delivery drops everything, including a fresh disk request.
        quantum_wr = 1'b1; quantum_data = 16'd3; userMode = 1'b1; tick("t6_enter");
        quantum_wr = 1'b0; userMode = 1'b0;
        for (int i = 0; i < 4; i++) tick("t6_run");
        check("t6_intc", intc, 32'd1);
        disk_done = 1'b1; tick("t6_disk");
        disk_done = 1'b0;
        do_reset();
        check("t6_rst_irq", 32'(irq), 32'd0);
        userMode = 1'b1; tick("t6_enter2");
        userMode = 1'b0;
        for (int i = 0; i < 20; i++) tick("t6_after");
        check("t6_no_irq", 32'(irq), 32'd0);
        kernelMode = 1'b1; tick("t6_leave");
        kernelMode = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            userMode     = ($urandom_range(0, 7) == 0);
            kernelMode   = ($urandom_range(0, 15) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            quantum_wr   = ($urandom_range(0, 31) == 0);
            quantum_data = QW'($urandom_range(0, 12));
            if ($urandom_range(0, 5) == 0) io_req = ~io_req;
            disk_done    = ($urandom_range(0, 24) == 0);
            ack          = ($urandom_range(0, 4) == 0);
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
